// File: rtl/main_fsm_controller.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute over 3-5 cycles per instruction.
// Stalls in FETCH/MEMREAD/MEMWRITE while i_mem_ready is low; unsupported opcodes park in TRAP until reset.
module main_fsm_controller (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;

  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BEQ;
          7'b1101111:             w_next = S_JAL;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = i_mem_ready;
        w_pc_update  = i_mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD:  w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every write and parks the selects on their FETCH values.
    if (i_reset) begin
      w_pc_update  = 1'b0;
      w_branch     = 1'b0;
      w_ir_write   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_adr_src    = 1'b0;
      w_result_src = 2'b10;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b10;
      w_alu_op     = 2'b00;
    end
  end

  assign o_pc_write   = w_pc_update | (w_branch & i_zero);
  assign o_adr_src    = w_adr_src;
  assign o_ir_write   = w_ir_write;
  assign o_mem_write  = w_mem_write;
  assign o_reg_write  = w_reg_write;
  assign o_result_src = w_result_src;
  assign o_alu_src_a  = w_alu_src_a;
  assign o_alu_src_b  = w_alu_src_b;
  assign o_alu_op     = w_alu_op;
  assign o_illegal    = r_illegal;
  assign o_state      = r_state;

endmodule

// File: tb/tb_main_fsm_controller.sv
// Directed bench for main_fsm_controller: per-cycle expected outputs are queued at drive time and checked after settling.
module tb_main_fsm_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [17:0] word;
  } exp_t;
  exp_t sb[$];

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  main_fsm_controller dut (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pc_write(pc_write), .o_adr_src(adr_src), .o_ir_write(ir_write),
    .o_mem_write(mem_write), .o_reg_write(reg_write), .o_result_src(result_src),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
    .o_illegal(illegal), .o_state(state)
  );

  always #5 clk = ~clk;

  // Select table per state: {adr_src, result_src, alu_src_a, alu_src_b, alu_op}
  function automatic logic [8:0] sel_of(input int st);
    case (st)
      0:  sel_of = {1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      1:  sel_of = {1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      2:  sel_of = {1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      3:  sel_of = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      4:  sel_of = {1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
      5:  sel_of = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      6:  sel_of = {1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      7:  sel_of = {1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
      9:  sel_of = {1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      10: sel_of = {1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
      default: sel_of = 9'd0;
    endcase
  endfunction

  // en = {pc_write, ir_write, mem_write, reg_write}
  task automatic step(input string tag, input logic rst, input logic [6:0] o,
                      input logic mr, input logic z, input int st,
                      input logic [3:0] en, input logic ill);
    exp_t e, got;
    logic [8:0]  sel;
    logic [17:0] obs;
    @(negedge clk);
    reset = rst; op = o; mem_ready = mr; zero = z;
    sel = rst ? sel_of(0) : sel_of(st);
    e.tag  = tag;
    e.word = {st[3:0], en[3], sel[8], en[2], en[1], en[0], sel[7:0], ill};
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    obs = {state, pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, illegal};
    vectors++;
    assert (obs === got.word) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", got.tag, obs, got.word);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step("reset_state", 1, OP_LW, 1, 0, 0, 4'b0000, 0);

    step("lw_fetch",   0, OP_LW, 1, 0, 0, 4'b1100, 0);
    step("lw_decode",  0, OP_LW, 1, 0, 1, 4'b0000, 0);
    step("lw_memadr",  0, OP_LW, 1, 0, 2, 4'b0000, 0);
    step("lw_memread", 0, OP_LW, 1, 0, 3, 4'b0000, 0);
    step("lw_memwb",   0, OP_LW, 1, 0, 4, 4'b0001, 0);

    step("sw_fetch_stall", 0, OP_SW, 0, 0, 0, 4'b0000, 0);
    step("sw_fetch",   0, OP_SW, 1, 0, 0, 4'b1100, 0);
    step("sw_decode",  0, OP_SW, 1, 0, 1, 4'b0000, 0);
    step("sw_memadr",  0, OP_SW, 1, 0, 2, 4'b0000, 0);
    step("sw_write0",  0, OP_SW, 0, 0, 5, 4'b0010, 0);
    step("sw_write1",  0, OP_SW, 0, 0, 5, 4'b0010, 0);
    step("sw_write2",  0, OP_SW, 1, 0, 5, 4'b0010, 0);

    step("beq1_fetch", 0, OP_BEQ, 1, 1, 0, 4'b1100, 0);
    step("beq1_decode",0, OP_BEQ, 1, 1, 1, 4'b0000, 0);
    step("beq1_taken", 0, OP_BEQ, 1, 1, 9, 4'b1000, 0);
    step("beq0_fetch", 0, OP_BEQ, 1, 0, 0, 4'b1100, 0);
    step("beq0_decode",0, OP_BEQ, 1, 0, 1, 4'b0000, 0);
    step("beq0_nottk", 0, OP_BEQ, 1, 0, 9, 4'b0000, 0);

    step("r_fetch",    0, OP_R, 1, 0, 0, 4'b1100, 0);
    step("r_decode",   0, OP_R, 1, 0, 1, 4'b0000, 0);
    step("r_execr",    0, OP_R, 1, 1, 6, 4'b0000, 0);
    step("r_aluwb",    0, OP_R, 1, 0, 8, 4'b0001, 0);
    step("i_fetch",    0, OP_I, 1, 0, 0, 4'b1100, 0);
    step("i_decode",   0, OP_I, 1, 0, 1, 4'b0000, 0);
    step("i_execi",    0, OP_I, 1, 0, 7, 4'b0000, 0);
    step("i_aluwb",    0, OP_I, 1, 0, 8, 4'b0001, 0);

    step("jal_fetch",  0, OP_JAL, 1, 0, 0, 4'b1100, 0);
    step("jal_decode", 0, OP_JAL, 1, 0, 1, 4'b0000, 0);
    step("jal_jal",    0, OP_JAL, 1, 0, 10, 4'b1000, 0);
    step("jal_aluwb",  0, OP_JAL, 1, 0, 8, 4'b0001, 0);

    step("bad_fetch",  0, OP_BAD, 1, 0, 0, 4'b1100, 0);
    step("bad_decode", 0, OP_BAD, 1, 0, 1, 4'b0000, 0);
    for (int i = 0; i < 12; i++)
      step("trap_hold", 0, OP_LW, 1, 1, 11, 4'b0000, 1);
    step("trap_reset", 1, OP_LW, 1, 1, 11, 4'b0000, 1);
    step("post_trap",  0, OP_LW, 0, 0, 0, 4'b0000, 0);

    step("rlw_fetch",  0, OP_LW, 1, 0, 0, 4'b1100, 0);
    step("rlw_decode", 0, OP_LW, 1, 0, 1, 4'b0000, 0);
    step("rlw_memadr", 0, OP_LW, 1, 0, 2, 4'b0000, 0);
    step("rlw_stall",  0, OP_LW, 0, 0, 3, 4'b0000, 0);
    step("rlw_reset",  1, OP_LW, 1, 0, 3, 4'b0000, 0);
    step("rlw_after",  0, OP_SW, 1, 0, 0, 4'b1100, 0);
    step("rsw_decode", 0, OP_SW, 1, 0, 1, 4'b0000, 0);
    step("rsw_memadr", 0, OP_SW, 1, 0, 2, 4'b0000, 0);
    step("rsw_write",  0, OP_SW, 0, 0, 5, 4'b0010, 0);
    step("rsw_reset",  1, OP_SW, 0, 0, 5, 4'b0000, 0);
    step("rsw_after",  0, OP_SW, 0, 0, 0, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
